// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data memory controller and its load aligner.
// Contents: RISC-V load/store funct3 width codes, controller state enum,
//           store byte-enable generator.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Lane enables for a store of the given width at byte offset off.
  // Non-store codes return no lanes so an illegal width can never write.
  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << off;
      F3_H:    be = 4'b0011 << off;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: combinational load-result formatter (shift down by byte offset, extend).
// Ports: i_word  - raw 32-bit memory word, i_off - byte offset addr[1:0],
//        i_funct3 - load width/sign code, o_rdata - aligned, extended load result.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;

  assign w_shifted = i_word >> {i_off, 3'b000};

  always_comb begin
    o_rdata = '0;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_rdata = i_word;
      F3_BU:   o_rdata = {24'd0, w_shifted[7:0]};
      F3_HU:   o_rdata = {16'd0, w_shifted[15:0]};
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed, handshaked data memory with per-lane writes and error reporting.
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata
//        request channel; resp_valid/resp_ready/resp_rdata/resp_err response channel.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      r_state, w_state_nxt;
  logic        w_accept;
  logic [29:0] w_rel_word;
  logic [AW-1:0] w_idx;
  logic        w_range_err, w_misalign, w_bad_f3, w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic        w_wr_en;

  logic [3:0][7:0] r_mem [DEPTH_WORDS] = '{default: '0};

  logic [31:0] r_rd_word;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;
  logic        r_ld_ok;
  logic        r_err;
  logic [31:0] w_aligned;
  logic [31:0] w_ld_dat;

  // Underflow (addr < BASE_ADDR) wraps to a huge offset and lands in the range check.
  assign w_rel_word  = 30'((req_addr - BASE_ADDR) >> 2);
  assign w_idx       = w_rel_word[AW-1:0];
  assign w_range_err = |w_rel_word[29:AW];

  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  assign w_bad_f3 = req_we ? !(req_funct3 inside {F3_B, F3_H, F3_W})
                           : !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

  assign w_err    = w_range_err | w_misalign | w_bad_f3;
  assign w_accept = req_valid && req_ready;
  assign w_wr_en  = w_accept && req_we && !w_err;
  assign w_be     = be_gen(req_funct3, req_addr[1:0]);

  always_comb begin
    w_wdata_rep = req_wdata;
    case (req_funct3)
      F3_B:    w_wdata_rep = {4{req_wdata[7:0]}};
      F3_H:    w_wdata_rep = {2{req_wdata[15:0]}};
      default: w_wdata_rep = req_wdata;
    endcase
  end

  // Storage and read port kept free of reset so byte-write RAM can be inferred.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rd_word <= r_mem[w_idx];
    end
    for (int i = 0; i < 4; i++) begin
      if (w_wr_en && w_be[i]) begin
        r_mem[w_idx][i] <= w_wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_off   <= '0;
      r_f3    <= '0;
      r_ld_ok <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_off   <= req_addr[1:0];
      r_f3    <= req_funct3;
      r_ld_ok <= !req_we && !w_err;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) w_state_nxt = (LATENCY == 2) ? WAIT : RESP;
      end
      WAIT: w_state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  dmem_load_align u_align (
    .i_word   (r_rd_word),
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .o_rdata  (w_aligned)
  );

  // Stores and rejected accesses report zero data.
  assign w_ld_dat = r_ld_ok ? w_aligned : 32'd0;
  assign resp_err = r_err;

  generate
    if (LATENCY == 2) begin : g_lat2
      logic [31:0] r_pipe_rdata;
      always_ff @(posedge clk) begin
        if (rst)                  r_pipe_rdata <= '0;
        else if (r_state == WAIT) r_pipe_rdata <= w_ld_dat;
      end
      assign resp_rdata = r_pipe_rdata;
    end else begin : g_lat1
      assign resp_rdata = w_ld_dat;
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl (default parameters).
// Drives on the falling edge, samples on the falling edge, DUT acts on the rising edge.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete access with resp_ready held high; returns data, error and
  // the number of cycles from the acceptance edge until resp_valid was seen.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1; resp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin @(negedge clk); lat++; end
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk);
  endtask

  // Access with data and error compared against hand-computed expectations.
  task automatic acc_chk(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic er;
    int lat;
    access(we, f3, addr, wd, rd, er, lat);
    check_val({tag, "_rdata"}, rd, exp_rd);
    check_val({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
    check_val({tag, "_lat"}, lat, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

    // A store presented during reset must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst_resp_rdata", resp_rdata, 32'd0);
    check_val("rst_resp_err", {31'd0, resp_err}, 32'd0);
    req_valid = 1'b0; req_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    acc_chk("lw_rst_store_ignored", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);

    // Word, byte and halfword stores/loads.
    acc_chk("sw_10",    1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    acc_chk("lw_10",    1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    acc_chk("sb_13",    1'b1, 3'b000, 32'h13, 32'h0000_005A, 32'h0, 1'b0);
    acc_chk("lw_10b",   1'b0, 3'b010, 32'h10, 32'h0, 32'h5AAD_BEEF, 1'b0);
    acc_chk("lb_13",    1'b0, 3'b000, 32'h13, 32'h0, 32'h0000_005A, 1'b0);
    acc_chk("lbu_12",   1'b0, 3'b100, 32'h12, 32'h0, 32'h0000_00AD, 1'b0);
    acc_chk("lb_12",    1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFF_FFAD, 1'b0);
    acc_chk("lb_10",    1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFEF, 1'b0);
    acc_chk("sh_16",    1'b1, 3'b001, 32'h16, 32'h1234_8001, 32'h0, 1'b0);
    acc_chk("lw_14",    1'b0, 3'b010, 32'h14, 32'h0, 32'h8001_0000, 1'b0);
    acc_chk("lh_16",    1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF_8001, 1'b0);
    acc_chk("lhu_16",   1'b0, 3'b101, 32'h16, 32'h0, 32'h0000_8001, 1'b0);
    acc_chk("lh_14",    1'b0, 3'b001, 32'h14, 32'h0, 32'h0000_0000, 1'b0);

    // Rejected accesses leave memory untouched.
    acc_chk("lw_11_mis",   1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1);
    acc_chk("sh_15_mis",   1'b1, 3'b001, 32'h15, 32'hFFFF_FFFF, 32'h0, 1'b1);
    acc_chk("lw_14_after_sh", 1'b0, 3'b010, 32'h14, 32'h0, 32'h8001_0000, 1'b0);
    acc_chk("st_f3_011",   1'b1, 3'b011, 32'h14, 32'hFFFF_FFFF, 32'h0, 1'b1);
    acc_chk("ld_f3_110",   1'b0, 3'b110, 32'h14, 32'h0, 32'h0, 1'b1);
    acc_chk("lw_14_after_f3", 1'b0, 3'b010, 32'h14, 32'h0, 32'h8001_0000, 1'b0);
    acc_chk("lw_oor",      1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
    acc_chk("sw_oor",      1'b1, 3'b010, 32'h1010, 32'hCAFE_F00D, 32'h0, 1'b1);
    acc_chk("lw_10_after_oor", 1'b0, 3'b010, 32'h10, 32'h0, 32'h5AAD_BEEF, 1'b0);
    acc_chk("lw_last",     1'b0, 3'b010, 32'hFFC, 32'h0, 32'h0, 1'b0);

    // Response held while the consumer stalls.
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_val("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
      check_val("stall_resp_rdata", resp_rdata, 32'h5AAD_BEEF);
      check_val("stall_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check_val("stall_release_valid", {31'd0, resp_valid}, 32'd0);
    check_val("stall_release_ready", {31'd0, req_ready}, 32'd1);

    // Reset while a store response is pending: response dropped, data kept.
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h1234_5678;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    check_val("pend_resp_valid", {31'd0, resp_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_drop_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst_drop_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0; resp_ready = 1'b1;
    #1;
    check_val("rst_drop_idle", {31'd0, req_ready}, 32'd1);
    acc_chk("lw_20_kept", 1'b0, 3'b010, 32'h20, 32'h0, 32'h1234_5678, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, handshaked data memory for the single-cycle core's load/store path, replacing the flat word-addressed array. It is a byte-addressed store with per-byte write lanes and correct sub-word placement from the low address bits. It does synchronous (registered) reads with configurable latency, and reports misaligned, out-of-range and illegal-width accesses through an error flag instead of silently corrupting memory. The block sits between the core's memory stage and any wait-capable bus master; one request is outstanding at a time.

## Interface
- DEPTH_WORDS, default 1024: number of 32-bit words; must be a power of two.
- LATENCY, default 1: cycles from request acceptance to response; legal values are 1 and 2, where 2 adds an output register.
- BASE_ADDR, default 32'h0000_0000: byte address of word 0.
- clk, input, 1: the single clock.
- rst, input, 1: reset, synchronous and active-high.
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request.
- req_we, input, 1: 1 = store, 0 = load.
- req_funct3, input, 3: RISC-V width/sign code. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data, right-aligned.
- resp_valid, output, 1: response present.
- resp_ready, input, 1: consumer accepts the response.
- resp_rdata, output, 32: load result, aligned and extended; 0 for stores and errors.
- resp_err, output, 1: the access was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP. WAIT is used only when LATENCY=2.
- IDLE:
  - req_ready=1.
  - On req_valid, the request is accepted at the edge.
  - Go to RESP, or to WAIT if LATENCY=2.
- WAIT: registers the read word; go to RESP after one cycle.
- RESP:
  - resp_valid=1.
  - resp_rdata and resp_err are held stable until resp_ready=1.
  - On that edge, return to IDLE.
- req_ready=0 in WAIT and RESP. New requests are never accepted in the same cycle as a response handshake.
- Word index is (req_addr-BASE_ADDR)>>2; the byte offset is addr[1:0].
- Error conditions (any one sets resp_err=1):
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - (req_addr-BASE_ADDR) ≥ 4·DEPTH_WORDS, including underflow, i.e. addr < BASE_ADDR.
  - Load funct3 ∈ {011, 110, 111}.
  - Store funct3 ∉ {000, 001, 010}.
- On error, no memory write occurs and resp_rdata=0.
- Store byte enables:
  - B: 1<<off.
  - H: 0011<<off, with off ∈ {0, 2}.
  - W: 1111.
- Store data is replicated into the lanes: B as {4{wdata[7:0]}}, H as {2{wdata[15:0]}}. Only enabled lanes are written.
- Load: the selected byte or halfword is shifted down by 8·off, then sign-extended for B/H or zero-extended for BU/HU. W passes through.
- Memory contents are zero at elaboration. rst does not clear memory.

## Timing
- Reset values: req_ready=0 while rst=1 and 1 in the cycle after; resp_valid=0, resp_rdata=0, resp_err=0; state=IDLE.
- rst dominates every edge. A request presented on an edge where rst=1 is not accepted and causes no write.
- Store commits at the acceptance edge. A load accepted on any later edge observes it (no hazard window).
- Load read occurs at the acceptance edge. With handshakes back to back, resp_valid is high in cycle N+LATENCY after acceptance at edge N.
- Throughput: one access per LATENCY+1 cycles when resp_ready is held at 1.
- rst asserted in WAIT or RESP drops the pending response. An already-committed store remains in memory.
- Response fields are registered; none is combinational from req_*.

## Structure
- Package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - the state enum {IDLE, WAIT, RESP}.
  - a function for byte-enable generation.
- Sub-module dmem_load_align (combinational): inputs are word, off and funct3; output is the 32-bit result. It is reused by the core's forwarding logic.
- Storage is one array of 4×8-bit lanes, written with per-lane enables so that synthesis infers byte-write RAM.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 → rdata=0xDEADBEEF, err=0; resp_valid arrives LATENCY cycles after acceptance.
- After the above, SB 0x5A to 0x13, then LW 0x10 → 0x5AADBEEF. Then LB 0x13 → 0x0000005A; LBU 0x12 → 0x000000AD; LB 0x12 → 0xFFFFFFAD.
- SH 0x8001 to 0x16, then LW 0x14 → 0x80010000. Then LH 0x16 → 0xFFFF8001; LHU 0x16 → 0x00008001.
- Error cases, each with memory unchanged:
  - LW 0x11 → err=1, rdata=0.
  - SH to 0x15 → err=1, and LW 0x14 is unchanged.
  - Store with funct3=011 → err=1.
  - Access at addr 4·DEPTH_WORDS → err=1.
- Hold resp_ready=0 for 5 cycles → resp_valid and resp_rdata stay stable and req_ready stays 0; then resp_ready=1 → IDLE on the next cycle.
- Assert rst during RESP after a store → resp_valid=0 next cycle and state=IDLE; a subsequent LW returns the stored value.
